// File: rtl/pixel_streamer_if.sv
// Pixel stream bus from pixel_streamer to the video output.
//   st_data  : RGB565 pixel
//   st_valid : st_data/st_sop/st_eop are valid
//   st_ready : sink accepts the pixel when high together with st_valid
//   st_sop   : first pixel of a frame
//   st_eop   : last pixel of a frame
interface pixel_streamer_if;
  logic [15:0] st_data;
  logic        st_valid;
  logic        st_ready;
  logic        st_sop;
  logic        st_eop;

  modport master (output st_data, output st_valid, output st_sop, output st_eop, input st_ready);
  modport slave  (input st_data, input st_valid, input st_sop, input st_eop, output st_ready);
endinterface

// File: rtl/pixel_streamer.sv
// pixel_streamer: turns the pixel iterator's sequence into reads of the
// per-solver iteration-count memories, colour-maps each returned count to
// RGB565 and emits a valid/ready pixel stream with start/end-of-frame flags.
// The iterator is throttled through iter_en using credits that cover both
// the output FIFO and the reads still travelling through the memory.
//
// Ports:
//   clock, reset  : system clock, asynchronous active-high reset
//   iter_en       : enable to iterator (a sample is taken when high)
//   solver_id     : solver selecting which memory's count is used
//   solver_addr   : read address for the pixel
//   start_stream  : first pixel of frame
//   end_stream    : last pixel of frame (always taken)
//   max_iter      : counts >= max_iter are in-set (black)
//   mem_rd_en     : read strobe to all solver memories
//   mem_rd_addr   : read address to all solver memories
//   mem_rd_data   : read data of all solvers, solver 0 in the LSBs
//   st            : output pixel stream (master side)
module pixel_streamer #(
  parameter int NUM_SOLVERS = 1,
  parameter int ITER_WIDTH  = 16,
  parameter int MEM_LATENCY = 2,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic                              clock,
  input  logic                              reset,
  output logic                              iter_en,
  input  logic [5:0]                        solver_id,
  input  logic [18:0]                       solver_addr,
  input  logic                              start_stream,
  input  logic                              end_stream,
  input  logic [ITER_WIDTH-1:0]             max_iter,
  output logic                              mem_rd_en,
  output logic [18:0]                       mem_rd_addr,
  input  logic [NUM_SOLVERS*ITER_WIDTH-1:0] mem_rd_data,
  pixel_streamer_if.master                  st
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  typedef struct packed {
    logic [5:0] id;
    logic       sop;
    logic       eop;
  } side_t;

  typedef struct packed {
    logic [15:0] data;
    logic        sop;
    logic        eop;
  } pix_t;

  function automatic logic [15:0] colour_map(input logic [ITER_WIDTH-1:0] c,
                                             input logic [ITER_WIDTH-1:0] lim);
    if (c >= lim) return 16'h0000;
    return {c[4:0], c[9:4], c[14:10]};
  endfunction

  logic [MEM_LATENCY-1:0] vld_q, vld_d;
  side_t                  side_q [MEM_LATENCY];
  side_t                  side_d [MEM_LATENCY];
  pix_t                   fifo_q [FIFO_DEPTH];
  logic [AW-1:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]          count_q, count_d;
  logic [CW-1:0]          inflight, free;
  logic                   take, push, pop, not_empty;
  logic [ITER_WIDTH-1:0]  ret_cnt;
  pix_t                   push_pix, head;

  // Credits: every taken sample owns a slot from the cycle after its take
  // until the cycle after it is popped.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < MEM_LATENCY; i++) inflight = inflight + CW'(vld_q[i]);
    free = DEPTH_C - count_q - inflight;
  end

  // Ordinary takes keep one slot in reserve for the end-of-frame take, which
  // the iterator performs whether enabled or not. Reset gates the enable
  // because the cleared state would otherwise advertise full credit.
  assign iter_en     = ~reset & (end_stream ? (free >= CW'(1)) : (free >= CW'(2)));
  assign take        = iter_en | (end_stream & ~reset);
  assign mem_rd_en   = take;
  assign mem_rd_addr = reset ? '0 : solver_addr;

  // Issue stage: sideband follows the read through the memory latency
  always_comb begin
    vld_d[0]  = take;
    side_d[0] = '{id: solver_id, sop: start_stream, eop: end_stream};
    for (int i = 1; i < MEM_LATENCY; i++) begin
      vld_d[i]  = vld_q[i-1];
      side_d[i] = side_q[i-1];
    end
  end

  // Return stage: select this pixel's solver slice and colour-map it
  always_comb begin
    ret_cnt = '0;
    for (int s = 0; s < NUM_SOLVERS; s++) begin
      if (side_q[MEM_LATENCY-1].id == 6'(s)) ret_cnt = mem_rd_data[s*ITER_WIDTH +: ITER_WIDTH];
    end
  end

  assign push     = vld_q[MEM_LATENCY-1];
  assign push_pix = '{data: colour_map(ret_cnt, max_iter),
                      sop:  side_q[MEM_LATENCY-1].sop,
                      eop:  side_q[MEM_LATENCY-1].eop};

  // Output FIFO stage: credits guarantee a push never meets a full FIFO
  assign not_empty = (count_q != '0);
  assign pop       = not_empty & st.st_ready;
  assign head      = fifo_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Outputs are forced low while empty so stale storage never shows.
  assign st.st_valid = not_empty;
  assign st.st_data  = not_empty ? head.data : 16'h0000;
  assign st.st_sop   = not_empty & head.sop;
  assign st.st_eop   = not_empty & head.eop;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      vld_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      vld_q    <= vld_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload storage carries no reset; its validity is tracked by vld_q/count_q.
  always_ff @(posedge clock) begin
    side_q <= side_d;
    if (push) fifo_q[wr_ptr_q] <= push_pix;
  end

endmodule

// File: tb/tb_pixel_streamer.sv
module tb_pixel_streamer;
  localparam int NS = 2;
  localparam int IW = 16;
  localparam int L  = 2;
  localparam int D  = 8;

  logic            clock = 1'b0;
  logic            reset;
  logic            iter_en;
  logic [5:0]      solver_id;
  logic [18:0]     solver_addr;
  logic            start_stream;
  logic            end_stream;
  logic [IW-1:0]   max_iter;
  logic            mem_rd_en;
  logic [18:0]     mem_rd_addr;
  logic [NS*IW-1:0] mem_rd_data;

  pixel_streamer_if st_if ();

  pixel_streamer #(.NUM_SOLVERS(NS), .ITER_WIDTH(IW), .MEM_LATENCY(L), .FIFO_DEPTH(D)) dut (
    .clock        (clock),
    .reset        (reset),
    .iter_en      (iter_en),
    .solver_id    (solver_id),
    .solver_addr  (solver_addr),
    .start_stream (start_stream),
    .end_stream   (end_stream),
    .max_iter     (max_iter),
    .mem_rd_en    (mem_rd_en),
    .mem_rd_addr  (mem_rd_addr),
    .mem_rd_data  (mem_rd_data),
    .st           (st_if)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int filler   = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, got, exp, cyc);
  endtask

  // Memory model: solver 0 returns count=addr (500 at 5, 499 at 6), solver 1 returns addr+4
  function automatic logic [15:0] cnt_of(input int s, input logic [18:0] a);
    if (s == 0) begin
      if (a == 19'd5) return 16'd500;
      if (a == 19'd6) return 16'd499;
      return a[15:0];
    end
    return a[15:0] + 16'd4;
  endfunction

  logic [18:0] apipe [L];
  always @(posedge clock) begin
    apipe[0] <= mem_rd_addr;
    for (int i = 1; i < L; i++) apipe[i] <= apipe[i-1];
  end
  always_comb mem_rd_data = {cnt_of(1, apipe[L-1]), cnt_of(0, apipe[L-1])};

  function automatic logic [15:0] ref_colour(input int c, input int lim);
    int r, g, b;
    if (c >= lim) return 16'h0000;
    r = c % 32;
    g = (c / 16) % 64;
    b = (c / 1024) % 32;
    return 16'(r * 2048 + g * 32 + b);
  endfunction

  typedef struct {
    logic [15:0] data;
    logic        sop;
    logic        eop;
    int          rdy;
  } exp_t;

  typedef struct {
    logic [15:0] data;
    logic        sop;
    logic        eop;
    int          cyc;
  } log_t;

  exp_t q[$];
  log_t dlog[$];
  int   take_cyc[$];
  int   outstanding = 0;

  // Model: items outstanding = taken minus popped; each pixel becomes visible
  // L+1 cycles after its take and leaves in take order.
  always @(negedge clock) begin
    int   free;
    logic tk, ev;
    if (reset) begin
      chk("reset_st_valid", int'(st_if.st_valid), 0);
      chk("reset_iter_en", int'(iter_en), 0);
      chk("reset_mem_rd_en", int'(mem_rd_en), 0);
      q.delete();
      dlog.delete();
      take_cyc.delete();
      outstanding = 0;
    end else begin
      free = D - outstanding;
      chk("iter_en", int'(iter_en), end_stream ? int'(free >= 1) : int'(free >= 2));
      if (end_stream) chk("forced_take_room", int'(free >= 1), 1);
      tk = end_stream || (free >= 2);
      chk("mem_rd_en", int'(mem_rd_en), int'(tk));
      if (tk) chk("mem_rd_addr", int'(mem_rd_addr), int'(solver_addr));
      ev = (q.size() > 0) && (q[0].rdy <= cyc);
      chk("st_valid", int'(st_if.st_valid), int'(ev));
      if (ev) begin
        chk("st_data", int'(st_if.st_data), int'(q[0].data));
        chk("st_sop", int'(st_if.st_sop), int'(q[0].sop));
        chk("st_eop", int'(st_if.st_eop), int'(q[0].eop));
      end
      if (st_if.st_valid && st_if.st_ready) begin
        dlog.push_back('{data: st_if.st_data, sop: st_if.st_sop, eop: st_if.st_eop, cyc: cyc});
        if (q.size() > 0) void'(q.pop_front());
        outstanding--;
      end
      if (tk) begin
        q.push_back('{data: ref_colour(int'(cnt_of(int'(solver_id), solver_addr)), int'(max_iter)),
                      sop: start_stream, eop: end_stream, rdy: cyc + L + 1});
        outstanding++;
      end
    end
  end

  // Present one pixel for one cycle; report whether it was taken.
  task automatic step(input logic [5:0] id, input logic [18:0] a, input logic s, input logic e,
                      output logic taken);
    solver_id    = id;
    solver_addr  = a;
    start_stream = s;
    end_stream   = e;
    @(negedge clock);
    taken = iter_en || end_stream;
    if (taken) take_cyc.push_back(cyc);
    @(posedge clock);
    #1;
  endtask

  // Hold a pixel until the streamer takes it; returns its take index.
  task automatic send(input logic [5:0] id, input logic [18:0] a, input logic s, input logic e,
                      output int idx);
    logic tk;
    idx = -1;
    for (int k = 0; k < 300; k++) begin
      step(id, a, s, e, tk);
      if (tk) begin
        idx = take_cyc.size() - 1;
        return;
      end
    end
    chk("send_timeout", 0, 1);
  endtask

  task automatic fill_step();
    logic tk;
    step(6'd0, 19'(200 + filler), 1'b0, 1'b0, tk);
    if (tk) filler++;
  endtask

  task automatic wait_log(input int n);
    for (int k = 0; k < 500; k++) begin
      if (dlog.size() >= n) return;
      fill_step();
    end
    chk("wait_log_timeout", dlog.size(), n);
  endtask

  // field: 0 = data, 1 = sop, 2 = eop
  task automatic pin(input string name, input int idx, input int field, input int exp);
    int got;
    if (idx < 0 || idx >= dlog.size()) begin
      chk(name, -1, exp);
      return;
    end
    got = (field == 0) ? int'(dlog[idx].data) : (field == 1) ? int'(dlog[idx].sop) : int'(dlog[idx].eop);
    chk(name, got, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int i0, i1, i2, i3, i5, i6, i7, i8, ie, is, j0, j3, ntk;
    logic tk;
    reset = 1'b1;
    solver_id = '0; solver_addr = '0; start_stream = 1'b0; end_stream = 1'b0;
    max_iter = 16'd500;
    st_if.st_ready = 1'b1;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    #1 chk("iter_en_after_reset", int'(iter_en), 1);

    // 4-pixel frame, count = addr
    send(6'd0, 19'd0, 1'b1, 1'b0, i0);
    send(6'd0, 19'd1, 1'b0, 1'b0, i1);
    send(6'd0, 19'd2, 1'b0, 1'b0, i2);
    send(6'd0, 19'd3, 1'b0, 1'b1, i3);
    wait_log(i3 + 1);
    pin("frame_px0", i0, 0, 16'h0000);
    pin("frame_px1", i1, 0, 16'h0800);
    pin("frame_px2", i2, 0, 16'h1000);
    pin("frame_px3", i3, 0, 16'h1800);
    pin("frame_sop0", i0, 1, 1);
    pin("frame_sop1", i1, 1, 0);
    pin("frame_eop2", i2, 2, 0);
    pin("frame_eop3", i3, 2, 1);
    if (i0 >= 0 && i3 >= 0 && dlog.size() > i0) begin
      chk("first_latency", dlog[i0].cyc - take_cyc[i0], 3);
      chk("back_to_back_takes", take_cyc[i3] - take_cyc[i0], 3);
    end else chk("frame_indices", 0, 1);

    // in-set limit, colour bit fields, solver select on a two-solver bus
    send(6'd0, 19'd5, 1'b0, 1'b0, i5);
    send(6'd0, 19'd6, 1'b0, 1'b0, i6);
    send(6'd1, 19'd3, 1'b0, 1'b0, i7);
    send(6'd0, 19'd3, 1'b0, 1'b0, i8);
    wait_log(i8 + 1);
    pin("count_eq_max", i5, 0, 16'h0000);
    pin("count_499", i6, 0, 16'h9BE0);
    pin("solver1_sel", i7, 0, 16'h3800);
    pin("solver0_sel", i8, 0, 16'h1800);

    // backpressure: credits stop ordinary takes at 7 outstanding
    st_if.st_ready = 1'b0;
    repeat (40) fill_step();
    chk("held_outstanding", take_cyc.size() - dlog.size(), 7);
    chk("iter_en_held_low", int'(iter_en), 0);
    send(6'd0, 19'd40, 1'b0, 1'b1, ie);
    chk("forced_take_full", take_cyc.size() - dlog.size(), 8);
    ntk = 0;
    for (int k = 0; k < 5; k++) begin
      step(6'd0, 19'd41, 1'b1, 1'b0, tk);
      if (tk) begin
        ntk++;
        void'(take_cyc.pop_back());
      end
    end
    chk("no_take_when_full", ntk, 0);
    st_if.st_ready = 1'b1;
    send(6'd0, 19'd41, 1'b1, 1'b0, is);
    wait_log(is + 1);
    pin("forced_eop", ie, 2, 1);
    pin("forced_data", ie, 0, 16'h4040);
    pin("next_frame_sop", is, 1, 1);
    for (int k = ie - 7; k < ie; k++) begin
      if (k >= 0 && k + 1 < dlog.size()) chk("release_no_gap", dlog[k+1].cyc - dlog[k].cyc, 1);
      else chk("release_index", k, 0);
    end

    // reset mid-flight with items in the pipeline and FIFO
    st_if.st_ready = 1'b0;
    repeat (6) fill_step();
    #1 reset = 1'b1;
    #1;
    chk("reset_now_st_valid", int'(st_if.st_valid), 0);
    chk("reset_now_iter_en", int'(iter_en), 0);
    @(posedge clock);
    #1 reset = 1'b0;
    st_if.st_ready = 1'b1;
    #1 chk("iter_en_after_midreset", int'(iter_en), 1);
    send(6'd0, 19'd0, 1'b1, 1'b0, j0);
    send(6'd0, 19'd1, 1'b0, 1'b0, i1);
    send(6'd0, 19'd2, 1'b0, 1'b0, i2);
    send(6'd0, 19'd3, 1'b0, 1'b1, j3);
    chk("post_reset_first_index", j0, 0);
    wait_log(j3 + 1);
    pin("post_reset_sop", 0, 1, 1);
    pin("post_reset_px0", 0, 0, 16'h0000);
    pin("post_reset_px3", 3, 0, 16'h1800);
    pin("post_reset_eop", 3, 2, 1);
    if (dlog.size() > 0 && take_cyc.size() > 0) chk("post_reset_latency", dlog[0].cyc - take_cyc[0], 3);
    else chk("post_reset_log", 0, 1);

    repeat (4) fill_step();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
